// File: rtl/debug_pkg.sv
// Shared types and constants for the debug_unit host-control block.
package debug_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LD_CNT,
        LD_BYTE,
        LD_WR,
        LD_ACK,
        RUN,
        STEP,
        DUMP_SEND,
        DUMP_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_WAIT
    } ser_state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] ACK_BYTE = 8'h06;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_serializer.sv
// Sends one NBITS word as BYTES_PER_WORD bytes, LSB first, over the UART
// transmit handshake, then pulses done_o for one cycle.
module word_serializer
    import debug_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int DBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [NBITS-1:0] word_i,
    input  logic             tx_done_i,
    output logic             tx_start_o,
    output logic [DBITS-1:0] tx_byte_o,
    output logic             done_o
);

    localparam int IW = $clog2(BYTES_PER_WORD);

    ser_state_t       state_q, state_d;
    logic [NBITS-1:0] word_q, word_d;
    logic [IW-1:0]    idx_q, idx_d;

    // The word is captured at start so the source may change while bytes go out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SER_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // Launch a byte, wait for the transmitter, repeat until the last byte is acknowledged.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        tx_start_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (start_i) begin
                    word_d  = word_i;
                    idx_d   = '0;
                    state_d = SER_SEND;
                end
            end
            SER_SEND: begin
                tx_start_o = 1'b1;
                state_d    = SER_WAIT;
            end
            SER_WAIT: begin
                if (tx_done_i) begin
                    if (idx_q == IW'(BYTES_PER_WORD - 1)) begin
                        done_o  = 1'b1;
                        state_d = SER_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SER_SEND;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    assign tx_byte_o = word_q[idx_q*DBITS +: DBITS];

endmodule

// File: rtl/debug_unit.sv
// Host-side debug controller: loads instruction memory from UART bytes,
// gates the pipeline for run/step, and dumps PC plus register bank.
// Optional macro DEBUG_UNIT_CYCLE_COUNT_EN adds an enabled-cycle counter
// to the dump (inserted right after the PC word).
module debug_unit
    import debug_pkg::*;
#(
    parameter int MEM_SIZE  = 5,
    parameter int BANK_SIZE = 32,
    parameter int NBITS     = 32,
    parameter int RBITS     = 5,
    parameter int DBITS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DBITS-1:0]    i_rx_data,
    input  logic                i_rx_done,
    input  logic                i_tx_done,
    output logic [DBITS-1:0]    o_tx_data,
    output logic                o_tx_start,
    output logic                o_imem_we,
    output logic [MEM_SIZE-1:0] o_imem_addr,
    output logic [NBITS-1:0]    o_imem_data,
    output logic                o_pipe_en,
    input  logic                i_halt,
    input  logic [NBITS-1:0]    i_pc,
    output logic [RBITS-1:0]    o_reg_addr,
    input  logic [NBITS-1:0]    i_reg_data
);

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int FIRST_REG = 2;
`else
    localparam int FIRST_REG = 1;
`endif
    localparam int NITEMS = FIRST_REG + BANK_SIZE;
    localparam int IW     = $clog2(NITEMS);
    localparam int BW     = $clog2(BYTES_PER_WORD);

    state_t              state_q, state_d;
    logic [MEM_SIZE-1:0] addr_q, addr_d;
    logic [BW-1:0]       bidx_q, bidx_d;
    logic [DBITS-1:0]    wcnt_q, wcnt_d;
    logic [DBITS-1:0]    nwords_q, nwords_d;
    logic [NBITS-1:0]    word_q, word_d;
    logic [NBITS-1:0]    pc_q, pc_d;
    logic [IW-1:0]       item_q, item_d;
    logic [RBITS-1:0]    raddr_q, raddr_d;
    logic [DBITS-1:0]    tx_data_q, tx_data_d;

    logic                ack_start, ser_start, ser_tx_start, ser_done;
    logic [DBITS-1:0]    ser_byte, tx_byte;
    logic [NBITS-1:0]    dump_word;

    // Control and load/dump bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            bidx_q    <= '0;
            wcnt_q    <= '0;
            nwords_q  <= '0;
            word_q    <= '0;
            pc_q      <= '0;
            item_q    <= '0;
            raddr_q   <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bidx_q    <= bidx_d;
            wcnt_q    <= wcnt_d;
            nwords_q  <= nwords_d;
            word_q    <= word_d;
            pc_q      <= pc_d;
            item_q    <= item_d;
            raddr_q   <= raddr_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Command decode, load sequencing, run/step gating and dump sequencing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bidx_d    = bidx_q;
        wcnt_d    = wcnt_q;
        nwords_d  = nwords_q;
        word_d    = word_q;
        pc_d      = pc_q;
        item_d    = item_q;
        raddr_d   = raddr_q;
        o_imem_we = 1'b0;
        o_pipe_en = 1'b0;
        ack_start = 1'b0;
        ser_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == DBITS'(CMD_LOAD)) begin
                        addr_d  = '0;
                        state_d = LD_CNT;
                    end else if (i_rx_data == DBITS'(CMD_CONT)) begin
                        state_d = RUN;
                    end else if (i_rx_data == DBITS'(CMD_STEP)) begin
                        state_d = STEP;
                    end
                end
            end
            LD_CNT: begin
                if (i_rx_done) begin
                    nwords_d = i_rx_data;
                    wcnt_d   = '0;
                    bidx_d   = '0;
                    state_d  = (i_rx_data == '0) ? LD_ACK : LD_BYTE;
                end
            end
            LD_BYTE: begin
                if (i_rx_done) begin
                    word_d[bidx_q*DBITS +: DBITS] = i_rx_data;
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == BW'(BYTES_PER_WORD - 1)) state_d = LD_WR;
                end
            end
            LD_WR: begin
                o_imem_we = 1'b1;
                addr_d    = addr_q + 1'b1;
                wcnt_d    = wcnt_q + 1'b1;
                state_d   = ((wcnt_q + 1'b1) == nwords_q) ? LD_ACK : LD_BYTE;
            end
            LD_ACK: begin
                ack_start = 1'b1;
                state_d   = IDLE;
            end
            RUN, STEP: begin
                o_pipe_en = (state_q == STEP) ? 1'b1 : ~i_halt;
                if (state_q == STEP || i_halt) begin
                    pc_d    = i_pc;
                    item_d  = '0;
                    raddr_d = '0;
                    state_d = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                ser_start = 1'b1;
                state_d   = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (ser_done) begin
                    if (item_q == IW'(NITEMS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        if (item_q >= IW'(FIRST_REG)) raddr_d = raddr_q + 1'b1;
                        item_d  = item_q + 1'b1;
                        state_d = DUMP_SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Count enabled pipeline cycles; a new load starts a fresh measurement.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && i_rx_done && i_rx_data == DBITS'(CMD_LOAD)) cyc_d = '0;
        else if (o_pipe_en) cyc_d = cyc_q + 1'b1;
    end

    // Cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;
    end
`endif

    // Select the word for the current dump item: PC, optional counter, then registers.
    always_comb begin
        dump_word = i_reg_data;
        if (item_q == '0) dump_word = pc_q;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
        else if (item_q == IW'(1)) dump_word = cyc_q;
`endif
    end

    word_serializer #(
        .NBITS(NBITS),
        .DBITS(DBITS)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .start_i   (ser_start),
        .word_i    (dump_word),
        .tx_done_i (i_tx_done),
        .tx_start_o(ser_tx_start),
        .tx_byte_o (ser_byte),
        .done_o    (ser_done)
    );

    // Transmit byte is shown during the start pulse and held afterwards.
    assign o_tx_start  = ack_start | ser_tx_start;
    assign tx_byte     = ack_start ? DBITS'(ACK_BYTE) : ser_byte;
    assign tx_data_d   = o_tx_start ? tx_byte : tx_data_q;
    assign o_tx_data   = tx_data_d;
    assign o_imem_addr = addr_q;
    assign o_imem_data = word_q;
    assign o_reg_addr  = raddr_q;

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: stimulus pushes expected writes and
// transmit bytes into queues; a monitor pops and compares as the DUT emits them.
module tb_debug_unit;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_tx_done;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_imem_we;
    logic [4:0]  o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_pipe_en;
    logic        i_halt;
    logic [31:0] i_pc;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;

    logic [31:0] regs [0:31];
    assign i_reg_data = regs[o_reg_addr];

    debug_unit dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_imem_we  (o_imem_we),
        .o_imem_addr(o_imem_addr),
        .o_imem_data(o_imem_data),
        .o_pipe_en  (o_pipe_en),
        .i_halt     (i_halt),
        .i_pc       (i_pc),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (i_reg_data)
    );

    initial forever #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          pipe_cnt = 0;
    int unsigned cyc_model = 0;
    logic [7:0]  exp_tx[$];
    logic [36:0] exp_wr[$];
    logic [31:0] ld_words[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples just before each rising edge.
    initial begin
        logic [36:0] ew;
        logic [7:0]  eb;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (o_pipe_en) pipe_cnt++;
                if (o_imem_we) begin
                    if (exp_wr.size() == 0) begin
                        total++; bad++;
                        $display("FAIL imem_wr: unexpected write addr=%0h data=%0h", o_imem_addr, o_imem_data);
                    end else begin
                        ew = exp_wr.pop_front();
                        check("imem_wr", {27'd0, o_imem_addr, o_imem_data}, {27'd0, ew});
                    end
                end
                if (o_tx_start) begin
                    if (exp_tx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL tx: unexpected byte %0h", o_tx_data);
                    end else begin
                        eb = exp_tx.pop_front();
                        check("tx_byte", {56'd0, o_tx_data}, {56'd0, eb});
                    end
                end
            end
        end
    end

    // UART transmitter stand-in: acknowledges each start after a random delay.
    initial begin
        int d;
        i_tx_done = 1'b0;
        @(negedge clk);
        forever begin
            #3;
            if (o_tx_start) begin
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic expect_dump(input logic [31:0] pc);
        push_word(pc);
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
        push_word(cyc_model);
`endif
        for (int k = 0; k < 32; k++) push_word(regs[k]);
    endtask

    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget && (exp_tx.size() != 0 || exp_wr.size() != 0); c++)
            @(negedge clk);
        total++;
        if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending tx=%0d wr=%0d required 0", name, exp_tx.size(), exp_wr.size());
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_tx_start"}, 64'(o_tx_start), 64'd0);
        check({tag, "_tx_data"}, 64'(o_tx_data), 64'd0);
        check({tag, "_imem_we"}, 64'(o_imem_we), 64'd0);
        check({tag, "_imem_addr"}, 64'(o_imem_addr), 64'd0);
        check({tag, "_imem_data"}, 64'(o_imem_data), 64'd0);
        check({tag, "_pipe_en"}, 64'(o_pipe_en), 64'd0);
        check({tag, "_reg_addr"}, 64'(o_reg_addr), 64'd0);
    endtask

    // Load the words in ld_words; the i-th word lands at i mod 32.
    task automatic do_load(input string name);
        int n;
        n = ld_words.size();
        cyc_model = 0;
        exp_tx.push_back(8'h06);
        send_byte(CMD_LOAD);
        send_byte(8'(n));
        for (int w = 0; w < n; w++) begin
            exp_wr.push_back({5'(w % 32), ld_words[w]});
            for (int b = 0; b < 4; b++) send_byte(ld_words[w][8*b +: 8]);
        end
        drain(name, 200);
        ld_words.delete();
    endtask

    task automatic do_step(input string name, input logic [31:0] pc);
        i_pc = pc;
        i_halt = 1'b1;
        pipe_cnt = 0;
        cyc_model += 1;
        expect_dump(pc);
        send_byte(CMD_STEP);
        send_byte(CMD_LOAD);
        drain(name, 2000);
        check({name, "_pipe_cycles"}, 64'(pipe_cnt), 64'd1);
        i_halt = 1'b0;
    endtask

    task automatic do_run(input string name, input int len, input logic [31:0] pc);
        i_pc = pc;
        i_halt = (len == 0);
        pipe_cnt = 0;
        cyc_model += len;
        expect_dump(pc);
        send_byte(CMD_CONT);
        repeat (len) @(negedge clk);
        i_halt = 1'b1;
        drain(name, 2000);
        check({name, "_pipe_cycles"}, 64'(pipe_cnt), 64'(len));
        i_halt = 1'b0;
    endtask

    initial begin
        int op;
        rst = 1'b1;
        i_rx_data = '0;
        i_rx_done = 1'b0;
        i_halt = 1'b0;
        i_pc = '0;
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        ld_words.push_back(32'h44332211);
        ld_words.push_back(32'h88776655);
        do_load("load2");

        for (int k = 0; k < 32; k++) regs[k] = 32'(k * 16);
        do_step("step", 32'h00000004);

        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        do_run("run7", 7, $urandom);

        pipe_cnt = 0;
        send_byte(8'h99);
        do_load("load0");
        check("ignored_pipe", 64'(pipe_cnt), 64'd0);

        do_run("run_halted", 0, $urandom);

        send_byte(CMD_LOAD);
        send_byte(8'h02);
        send_byte(8'hAB);
        send_byte(8'hCD);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outs("midload_rst");
        @(negedge clk);
        rst = 1'b0;
        cyc_model = 0;
        ld_words.push_back($urandom);
        do_load("load_after_rst");

        for (int w = 0; w < 33; w++) ld_words.push_back($urandom);
        do_load("load33");

        for (int it = 0; it < 5; it++) begin
            op = $urandom_range(0, 2);
            for (int k = 0; k < 32; k++) regs[k] = $urandom;
            if (op == 0) begin
                for (int w = 0; w < int'($urandom_range(1, 6)); w++) ld_words.push_back($urandom);
                do_load("rand_load");
            end else if (op == 1) begin
                do_step("rand_step", $urandom);
            end else begin
                do_run("rand_run", $urandom_range(0, 10), $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
